// File: rtl/ram_pkg.sv
// Shared definitions for the 1-write / 2-read synchronous RAM:
// default base address, byte-lane helpers and address range checking.
package ram_pkg;

  // Byte address of word 0 (program start).
  localparam logic [63:0] BASE_ADDR_DEFAULT = 64'h0000_0000_8000_0000;

  // Widest supported word, in byte lanes; helpers work at this width.
  localparam int unsigned MAX_LANES = 64;

  // Result of translating a byte address into a word index.
  typedef struct packed {
    logic        in_range;
    logic [63:0] index;
  } addr_chk_t;

  // Number of byte lanes in a word of data_w bits.
  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / 32'd8;
  endfunction

  // Expand per-byte enables into a per-bit mask.
  function automatic logic [MAX_LANES*8-1:0] be_to_mask(input logic [MAX_LANES-1:0] be);
    logic [MAX_LANES*8-1:0] mask;
    mask = '0;
    for (int k = 0; k < MAX_LANES; k++) begin
      mask[k*8 +: 8] = {8{be[k]}};
    end
    return mask;
  endfunction

  // Word index relative to base; in range only at or above base and below depth.
  function automatic addr_chk_t addr_check(input logic [63:0]   addr,
                                           input logic [63:0]   base,
                                           input int unsigned   lane_shift,
                                           input int unsigned   depth);
    addr_chk_t   chk;
    logic [63:0] off;
    off          = addr - base;
    chk.index    = off >> lane_shift;
    chk.in_range = (addr >= base) && (chk.index < 64'(depth));
    return chk;
  endfunction

endpackage

// File: rtl/ram_resp_buf.sv
// One-entry valid/ready response holding register. A new payload is loaded
// whenever a request is accepted; the held payload stays stable while the
// consumer stalls, and the request side is blocked only in that case.
module ram_resp_buf
  import ram_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid_i,
  input  logic [W-1:0] payload_i,
  input  logic         resp_ready_i,
  output logic         req_ready_o,
  output logic         resp_valid_o,
  output logic [W-1:0] payload_o
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] payload_q;
  logic [W-1:0] payload_d;
  logic         accept_s;

  assign req_ready_o  = !valid_q || resp_ready_i;
  assign accept_s     = req_valid_i && req_ready_o;
  assign resp_valid_o = valid_q;
  assign payload_o    = payload_q;

  // Next state: load on accept, drop on handshake, otherwise hold.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (accept_s) begin
      valid_d   = 1'b1;
      payload_d = payload_i;
    end else if (resp_ready_i) begin
      valid_d   = 1'b0;
    end else begin
      valid_d   = valid_q;
    end
  end

  // Response register; cleared by reset so pending responses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

endmodule

// File: rtl/ram_1w2r_sync.sv
// Synchronous RAM with one instruction-fetch read port (I) and one data
// load/store port (D). Each port has a valid/ready request, a one-cycle
// registered response and a one-entry response buffer; out-of-range
// addresses return err with zero data and never touch the array.
// Optional macro RAM_WRITE_FIRST_EN: an I read colliding with a D write on
// the same word in the same accept cycle returns the newly merged word
// (bypass); without it the I read returns the old word.
module ram_1w2r_sync
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned ADDR_W    = 64,
  parameter logic [63:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req_valid,
  output logic                 i_req_ready,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic                 i_resp_valid,
  input  logic                 i_resp_ready,
  output logic [31:0]          i_inst,
  output logic                 i_err,
  input  logic                 d_req_valid,
  output logic                 d_req_ready,
  input  logic                 d_we,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [DATA_W-1:0]    d_wdata,
  input  logic [DATA_W/8-1:0]  d_be,
  output logic                 d_resp_valid,
  input  logic                 d_resp_ready,
  output logic [DATA_W-1:0]    d_rdata,
  output logic                 d_err
);

  localparam int unsigned LANES      = lane_count(DATA_W);
  localparam int unsigned LANE_SHIFT = $clog2(LANES);
  localparam int unsigned IDX_W      = $clog2(DEPTH);

  logic [DATA_W-1:0]      mem_q [DEPTH];

  addr_chk_t              i_chk_s;
  addr_chk_t              d_chk_s;
  logic [IDX_W-1:0]       i_idx_s;
  logic [IDX_W-1:0]       d_idx_s;
  logic                   i_acc_s;
  logic                   d_acc_s;
  logic                   d_wr_en_s;
  logic [MAX_LANES*8-1:0] d_mask_full_s;
  logic [DATA_W-1:0]      d_mask_s;
  logic [DATA_W-1:0]      d_merged_s;
  logic [DATA_W-1:0]      i_word_s;
  logic [31:0]            i_slice_s;
  logic [32:0]            i_payload_s;
  logic [DATA_W:0]        d_payload_s;
  logic                   unused_s;

  assign i_chk_s = addr_check(64'(i_addr), BASE_ADDR, LANE_SHIFT, DEPTH);
  assign d_chk_s = addr_check(64'(d_addr), BASE_ADDR, LANE_SHIFT, DEPTH);
  assign i_idx_s = i_chk_s.index[IDX_W-1:0];
  assign d_idx_s = d_chk_s.index[IDX_W-1:0];

  assign i_acc_s = i_req_valid && i_req_ready;
  assign d_acc_s = d_req_valid && d_req_ready;

  assign d_mask_full_s = be_to_mask(MAX_LANES'(d_be));
  assign d_mask_s      = d_mask_full_s[DATA_W-1:0];
  assign d_wr_en_s     = d_acc_s && d_we && d_chk_s.in_range;
  assign d_merged_s    = (mem_q[d_idx_s] & ~d_mask_s) | (d_wdata & d_mask_s);

  // High index bits are already folded into the range check.
  assign unused_s = ^{i_chk_s.index[63:IDX_W], d_chk_s.index[63:IDX_W],
                      d_mask_full_s[MAX_LANES*8-1:DATA_W]};

  // Array write port: byte-lane merge committed at the accepting edge.
  always_ff @(posedge clk) begin
    if (d_wr_en_s) begin
      mem_q[d_idx_s] <= d_merged_s;
    end
  end

  // Word seen by the fetch port, with optional same-cycle write bypass.
  always_comb begin
    i_word_s = mem_q[i_idx_s];
`ifdef RAM_WRITE_FIRST_EN
    if (d_wr_en_s && (d_idx_s == i_idx_s)) begin
      i_word_s = d_merged_s;
    end else begin
      i_word_s = mem_q[i_idx_s];
    end
`endif
  end

  // Pick the 32-bit instruction slice addressed inside the word.
  if (LANE_SHIFT > 2) begin : g_slice_sel
    logic [LANE_SHIFT-3:0] sel_s;
    assign sel_s     = i_addr[LANE_SHIFT-1:2];
    assign i_slice_s = i_word_s[{sel_s, 5'd0} +: 32];
  end else begin : g_slice_whole
    assign i_slice_s = i_word_s[31:0];
  end

  // Fetch response payload {err, inst}; out of range returns err with zero data.
  always_comb begin
    i_payload_s = {1'b1, 32'h0000_0000};
    if (i_chk_s.in_range) begin
      i_payload_s = {1'b0, i_slice_s};
    end else begin
      i_payload_s = {1'b1, 32'h0000_0000};
    end
  end

  // Data response payload {err, rdata}; writes and errors return zero data.
  always_comb begin
    d_payload_s = {1'b1, {DATA_W{1'b0}}};
    if (!d_chk_s.in_range) begin
      d_payload_s = {1'b1, {DATA_W{1'b0}}};
    end else if (d_we) begin
      d_payload_s = {1'b0, {DATA_W{1'b0}}};
    end else begin
      d_payload_s = {1'b0, mem_q[d_idx_s]};
    end
  end

  ram_resp_buf #(.W(33)) u_i_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (i_req_valid),
    .payload_i    (i_payload_s),
    .resp_ready_i (i_resp_ready),
    .req_ready_o  (i_req_ready),
    .resp_valid_o (i_resp_valid),
    .payload_o    ({i_err, i_inst})
  );

  ram_resp_buf #(.W(DATA_W + 1)) u_d_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (d_req_valid),
    .payload_i    (d_payload_s),
    .resp_ready_i (d_resp_ready),
    .req_ready_o  (d_req_ready),
    .resp_valid_o (d_resp_valid),
    .payload_o    ({d_err, d_rdata})
  );

endmodule

// File: tb/tb_ram_1w2r_sync.sv
// Self-checking bench for ram_1w2r_sync: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model (word map plus a pending-response queue per port).
module tb_ram_1w2r_sync;

  localparam int          DATA_W = 64;
  localparam int          DEPTH  = 4096;
  localparam int          ADDR_W = 64;
  localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready, i_err;
  logic [63:0] i_addr;
  logic [31:0] i_inst;
  logic        d_req_valid, d_req_ready, d_we, d_resp_valid, d_resp_ready, d_err;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_be;

  always #5 clk = ~clk;

  ram_1w2r_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready), .i_inst(i_inst), .i_err(i_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be), .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
    .d_rdata(d_rdata), .d_err(d_err)
  );

  int checks   = 0;
  int failures = 0;
  bit model_on = 1'b0;

  typedef struct {
    bit          known;
    bit          err;
    logic [63:0] data;
  } resp_t;

  resp_t       iq[$];
  resp_t       dq[$];
  logic [63:0] mm [longint];

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (((a - BASE) >> 3) < 64'(DEPTH));
  endfunction

  function automatic longint idx_of(input logic [63:0] a);
    return longint'((a - BASE) >> 3);
  endfunction

  // Model state used only by the compare process.
  bit          exp_ir, exp_dr, i_acc, d_acc, d_wr, nw_known, w_known;
  longint      didx, iidx;
  logic [63:0] nw, w;
  resp_t       r;

  // Compare DUT against the model, then advance the model by this edge.
  always @(negedge clk) begin
    if (model_on) begin
      exp_ir = (iq.size() == 0) || i_resp_ready;
      exp_dr = (dq.size() == 0) || d_resp_ready;
      chk1("i_resp_valid", i_resp_valid, iq.size() != 0);
      chk1("i_req_ready", i_req_ready, exp_ir);
      chk1("d_resp_valid", d_resp_valid, dq.size() != 0);
      chk1("d_req_ready", d_req_ready, exp_dr);
      if (iq.size() != 0) begin
        chk1("i_err", i_err, iq[0].err);
        if (iq[0].known) chk64("i_inst", 64'(i_inst), iq[0].data);
      end
      if (dq.size() != 0) begin
        chk1("d_err", d_err, dq[0].err);
        if (dq[0].known) chk64("d_rdata", d_rdata, dq[0].data);
      end
      i_acc = i_req_valid && exp_ir;
      d_acc = d_req_valid && exp_dr;
      if (iq.size() != 0 && i_resp_ready) void'(iq.pop_front());
      if (dq.size() != 0 && d_resp_ready) void'(dq.pop_front());
      d_wr     = d_acc && d_we && in_rng(d_addr);
      nw_known = 1'b0;
      nw       = 64'h0;
      didx     = -1;
      if (d_wr) begin
        didx     = idx_of(d_addr);
        nw       = mm.exists(didx) ? mm[didx] : 64'h0;
        for (int k = 0; k < 8; k++) begin
          if (d_be[k]) nw[k*8 +: 8] = d_wdata[k*8 +: 8];
        end
        nw_known = mm.exists(didx) || (d_be == 8'hFF);
      end
      if (i_acc) begin
        if (!in_rng(i_addr)) begin
          r.known = 1'b1; r.err = 1'b1; r.data = 64'h0;
        end else begin
          iidx    = idx_of(i_addr);
          w_known = mm.exists(iidx);
          w       = w_known ? mm[iidx] : 64'h0;
`ifdef RAM_WRITE_FIRST_EN
          if (d_wr && (didx == iidx)) begin
            w       = nw;
            w_known = nw_known;
          end
`endif
          r.known = w_known;
          r.err   = 1'b0;
          r.data  = i_addr[2] ? 64'(w[63:32]) : 64'(w[31:0]);
        end
        iq.push_back(r);
      end
      if (d_acc) begin
        if (!in_rng(d_addr)) begin
          r.known = 1'b1; r.err = 1'b1; r.data = 64'h0;
        end else if (d_we) begin
          r.known = 1'b1; r.err = 1'b0; r.data = 64'h0;
        end else begin
          r.known = mm.exists(idx_of(d_addr));
          r.err   = 1'b0;
          r.data  = r.known ? mm[idx_of(d_addr)] : 64'h0;
        end
        dq.push_back(r);
      end
      if (d_wr && nw_known) mm[didx] = nw;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dreq(input bit we, input logic [63:0] a, input logic [63:0] wd, input logic [7:0] be);
    d_req_valid = 1'b1;
    d_we        = we;
    d_addr      = a;
    d_wdata     = wd;
    d_be        = be;
  endtask

  function automatic logic [63:0] pick_addr(input bit for_i);
    int unsigned sel;
    sel = $urandom_range(0, 19);
    if (sel < 16) begin
      return BASE + 64'(sel) * 64'd8 + (for_i ? 64'($urandom_range(0, 1)) * 64'd4
                                              : 64'($urandom_range(0, 7)));
    end else if (sel == 16) begin
      return BASE - 64'd8;
    end else if (sel == 17) begin
      return BASE + 64'(DEPTH) * 64'd8;
    end else if (sel == 18) begin
      return 64'hFFFF_FFFF_FFFF_FFF8;
    end else begin
      return BASE + 64'(DEPTH - 1) * 64'd8;
    end
  endfunction

  initial begin
    rst_n = 1'b0;
    i_req_valid = 1'b0; i_addr = 64'h0; i_resp_ready = 1'b0;
    d_req_valid = 1'b0; d_we = 1'b0; d_addr = 64'h0; d_wdata = 64'h0; d_be = 8'h0;
    d_resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_i_resp_valid", i_resp_valid, 1'b0);
    chk1("rst_d_resp_valid", d_resp_valid, 1'b0);
    chk1("rst_i_err", i_err, 1'b0);
    chk1("rst_d_err", d_err, 1'b0);
    chk64("rst_i_inst", 64'(i_inst), 64'h0);
    chk64("rst_d_rdata", d_rdata, 64'h0);
    rst_n = 1'b1;
    model_on = 1'b1;
    i_resp_ready = 1'b1;
    d_resp_ready = 1'b1;

    // Full write then read back with one-cycle latency.
    dreq(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF); step();
    chk1("wr_resp_valid", d_resp_valid, 1'b1);
    chk64("wr_resp_data", d_rdata, 64'h0);
    dreq(1'b0, 64'h8000_0008, 64'h0, 8'h00); step();
    chk1("rd_resp_valid", d_resp_valid, 1'b1);
    chk64("rd_full", d_rdata, 64'h1122_3344_5566_7788);
    chk1("rd_err", d_err, 1'b0);

    // Partial byte-enable write.
    dreq(1'b1, 64'h8000_0008, 64'hFFFF_FFFF_AAAA_BBBB, 8'h0F); step();
    dreq(1'b0, 64'h8000_0008, 64'h0, 8'h00); step();
    chk64("rd_partial", d_rdata, 64'h1122_3344_AAAA_BBBB);

    // Back-to-back fetches of both halves.
    dreq(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF); step();
    d_req_valid = 1'b0;
    i_req_valid = 1'b1; i_addr = 64'h8000_0008; step();
    chk64("fetch_lo", 64'(i_inst), 64'h5566_7788);
    chk1("fetch_ready0", i_req_ready, 1'b1);
    i_addr = 64'h8000_000C; step();
    chk64("fetch_hi", 64'(i_inst), 64'h1122_3344);
    chk1("fetch_ready1", i_req_ready, 1'b1);
    i_req_valid = 1'b0;

    // Backpressure: response held stable, request blocked.
    d_resp_ready = 1'b0;
    dreq(1'b0, 64'h8000_0008, 64'h0, 8'h00); step();
    for (int c = 0; c < 3; c++) begin
      chk1("hold_valid", d_resp_valid, 1'b1);
      chk64("hold_data", d_rdata, 64'h1122_3344_5566_7788);
      chk1("hold_req_ready", d_req_ready, 1'b0);
      step();
    end
    d_resp_ready = 1'b1;
    dreq(1'b1, 64'h8000_0018, 64'hCAFE_F00D_1234_5678, 8'hFF);
    #1;
    chk1("release_req_ready", d_req_ready, 1'b1);
    step();
    chk1("release_new_valid", d_resp_valid, 1'b1);
    chk64("release_new_data", d_rdata, 64'h0);

    // Out-of-range accesses.
    dreq(1'b1, 64'h8000_0000, 64'h0A0B_0C0D_0102_0304, 8'hFF); step();
    dreq(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00); step();
    chk1("oor_lo_err", d_err, 1'b1);
    chk64("oor_lo_data", d_rdata, 64'h0);
    dreq(1'b1, BASE + 64'(DEPTH) * 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF); step();
    chk1("oor_hi_err", d_err, 1'b1);
    dreq(1'b0, 64'h8000_0000, 64'h0, 8'h00); step();
    chk64("oor_no_alias", d_rdata, 64'h0A0B_0C0D_0102_0304);
    chk1("oor_no_alias_err", d_err, 1'b0);
    d_req_valid = 1'b0;
    i_req_valid = 1'b1; i_addr = 64'h7FFF_FFF8; step();
    chk1("i_oor_err", i_err, 1'b1);
    chk64("i_oor_inst", 64'(i_inst), 64'h0);
    i_req_valid = 1'b0;

    // Same-cycle fetch and write to one word.
    dreq(1'b1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF); step();
    i_req_valid = 1'b1; i_addr = 64'h8000_0010;
    dreq(1'b1, 64'h8000_0010, 64'hDEAD_BEEF_0000_0001, 8'hFF); step();
`ifdef RAM_WRITE_FIRST_EN
    chk64("collide_inst", 64'(i_inst), 64'h0000_0001);
`else
    chk64("collide_inst", 64'(i_inst), 64'h89AB_CDEF);
`endif
    i_req_valid = 1'b0;
    dreq(1'b0, 64'h8000_0010, 64'h0, 8'h00); step();
    chk64("collide_readback", d_rdata, 64'hDEAD_BEEF_0000_0001);
    d_req_valid = 1'b0;
    step();
    chk64("model_word0", mm[0], 64'h0A0B_0C0D_0102_0304);
    chk64("model_word1", mm[1], 64'h1122_3344_5566_7788);
    chk64("model_word2", mm[2], 64'hDEAD_BEEF_0000_0001);

    // Preload the random window so every in-range read has a known value.
    for (int i = 0; i < 17; i++) begin
      dreq(1'b1, (i == 16) ? BASE + 64'(DEPTH - 1) * 64'd8 : BASE + 64'(i) * 64'd8,
           {$urandom, $urandom}, 8'hFF);
      step();
    end
    d_req_valid = 1'b0;

    // Randomized traffic on both ports.
    for (int n = 0; n < 3000; n++) begin
      i_req_valid  = ($urandom_range(0, 9) < 7);
      i_addr       = pick_addr(1'b1);
      i_resp_ready = ($urandom_range(0, 9) < 7);
      d_req_valid  = ($urandom_range(0, 9) < 7);
      d_we         = $urandom_range(0, 1) == 1;
      d_addr       = pick_addr(1'b0);
      d_wdata      = {$urandom, $urandom};
      d_be         = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      d_resp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    i_resp_ready = 1'b1; d_resp_ready = 1'b1;
    repeat (3) step();

    // Reset with responses pending drops them immediately.
    model_on = 1'b0;
    i_req_valid = 1'b1; i_addr = BASE; i_resp_ready = 1'b0;
    dreq(1'b0, BASE, 64'h0, 8'h00); d_resp_ready = 1'b0;
    step();
    chk1("pre_rst_i_valid", i_resp_valid, 1'b1);
    chk1("pre_rst_d_valid", d_resp_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_i_valid", i_resp_valid, 1'b0);
    chk1("mid_rst_d_valid", d_resp_valid, 1'b0);
    chk64("mid_rst_d_rdata", d_rdata, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
